// File: rtl/bcd4bit_ascii8bit.sv
// BCD digit to ASCII character converter with registered outputs, an
// invalid-code flag and a saturating invalid-code counter.
module bcd4bit_ascii8bit #(
    parameter int N     = 4,
    parameter int M     = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     A,
    input  logic             in_valid,
    output logic [M-1:0]     B,
    output logic             C,
    output logic             out_valid,
    output logic [ERR_W-1:0] err_count
);

    generate
        if (N != 4 || M != 8) begin : g_bad_param
            $error("bcd4bit_ascii8bit: only N=4 and M=8 are supported");
        end
    endgenerate

    localparam int CODES = 1 << N;

    // Constant lookup table: digits map to '0'..'9', everything else to '?'.
    logic [M-1:0] ascii_lut [CODES];
    logic         bad_lut   [CODES];

    genvar gi;
    generate
        for (gi = 0; gi < CODES; gi++) begin : g_lut
            assign ascii_lut[gi] = (gi < 10) ? M'(8'h30 + gi) : M'(8'h3F);
            assign bad_lut[gi]   = (gi >= 10);
        end
    endgenerate

    logic [M-1:0]     ascii_reg;
    logic             bad_reg;
    logic             out_valid_reg;
    logic [ERR_W-1:0] err_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ascii_reg     <= '0;
            bad_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            err_count_reg <= '0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                ascii_reg <= ascii_lut[A];
                bad_reg   <= bad_lut[A];
                // Saturate rather than wrap so a flood of bad codes stays visible.
                if (bad_lut[A] && !(&err_count_reg)) begin
                    err_count_reg <= err_count_reg + 1'b1;
                end
            end
        end
    end

    assign B         = ascii_reg;
    assign C         = bad_reg;
    assign out_valid = out_valid_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_bcd4bit_ascii8bit.sv
// Directed-vector bench for bcd4bit_ascii8bit; a second instance with a
// 2-bit error counter exercises saturation.
module tb_bcd4bit_ascii8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic       in_valid;
    logic [7:0] b;
    logic       c;
    logic       out_valid;
    logic [7:0] err_count;

    logic [3:0] a_sat;
    logic       in_valid_sat;
    logic [7:0] b_sat;
    logic       c_sat;
    logic       out_valid_sat;
    logic [1:0] err_count_sat;

    int vec_count   = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd4bit_ascii8bit #(.N(4), .M(8), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a),
        .in_valid  (in_valid),
        .B         (b),
        .C         (c),
        .out_valid (out_valid),
        .err_count (err_count)
    );

    bcd4bit_ascii8bit #(.N(4), .M(8), .ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .A         (a_sat),
        .in_valid  (in_valid_sat),
        .B         (b_sat),
        .C         (c_sat),
        .out_valid (out_valid_sat),
        .err_count (err_count_sat)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".B"}, 32'(b), 32'h00);
        check_eq({tag, ".C"}, 32'(c), 32'h0);
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'h0);
        check_eq({tag, ".err_count"}, 32'(err_count), 32'h0);
    endtask

    // Drive one cycle of input, then sample 1ns after the capturing edge.
    task automatic apply(input logic [3:0] code, input logic vld);
        a        = code;
        in_valid = vld;
        @(posedge clk);
        #1;
        $display("txn A=%0d in_valid=%0b -> B=0x%02h C=%0b out_valid=%0b err_count=%0d",
                 code, vld, b, c, out_valid, err_count);
    endtask

    task automatic check_out(input string tag, input logic [7:0] exp_b, input logic exp_c,
                             input logic exp_ov, input logic [7:0] exp_err);
        check_eq({tag, ".B"}, 32'(b), 32'(exp_b));
        check_eq({tag, ".C"}, 32'(c), 32'(exp_c));
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
        check_eq({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
    endtask

    logic [7:0] exp_ascii [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                   8'h38, 8'h39, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
    logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst          = 1'b1;
        a            = 4'd0;
        in_valid     = 1'b0;
        a_sat        = 4'd0;
        in_valid_sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst = 1'b0;

        // Asynchronous reset between edges, after an invalid capture.
        apply(4'd12, 1'b1);
        check_out("pre_arst", 8'h3F, 1'b1, 1'b1, 8'd1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("arst");
        #1 rst = 1'b0;

        // Valid sweep, back to back.
        for (int i = 0; i < 10; i++) begin
            apply(4'(i), 1'b1);
            check_out($sformatf("valid%0d", i), exp_ascii[i], 1'b0, 1'b1, 8'd0);
        end

        // Invalid sweep 10..15 then a repeat of 15.
        for (int i = 0; i < 7; i++) begin
            logic [3:0] code;
            code = (i < 6) ? 4'(10 + i) : 4'd15;
            apply(code, 1'b1);
            check_out($sformatf("invalid%0d", code), 8'h3F, 1'b1, 1'b1, 8'(i + 1));
        end

        // Idle hold.
        apply(4'd5, 1'b1);
        check_out("hold_cap", 8'h35, 1'b0, 1'b1, 8'd7);
        for (int i = 0; i < 3; i++) begin
            apply(4'd8, 1'b0);
            check_out($sformatf("hold%0d", i), 8'h35, 1'b0, 1'b0, 8'd7);
        end

        // Saturation on the 2-bit counter instance.
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_sat        = 4'(10 + i);
            in_valid_sat = 1'b1;
            @(posedge clk);
            #1;
            $display("txn sat A=%0d -> B=0x%02h C=%0b err_count=%0d", a_sat, b_sat, c_sat, err_count_sat);
            check_eq($sformatf("sat%0d.err_count", i), 32'(err_count_sat), 32'(exp_sat[i]));
            check_eq($sformatf("sat%0d.C", i), 32'(c_sat), 32'h1);
        end
        in_valid_sat = 1'b0;
        check_eq("sat.main_err_idle", 32'(err_count), 32'd7);

        // Reset during a back-to-back stream.
        for (int i = 0; i < 3; i++) begin
            apply(4'd9, 1'b1);
            check_out($sformatf("stream%0d", i), 8'h39, 1'b0, 1'b1, 8'd7);
        end
        rst = 1'b1;
        #1 check_reset_vals("midrst");
        @(posedge clk);
        #1 check_reset_vals("midrst_edge");
        check_eq("midrst.sat_err", 32'(err_count_sat), 32'd0);
        #2 rst = 1'b0;
        apply(4'd2, 1'b1);
        check_out("post_rst", 8'h32, 1'b0, 1'b1, 8'd0);
        apply(4'd2, 1'b0);
        check_out("post_rst_idle", 8'h32, 1'b0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
